mat_vec_mult_skew: RTL and testbench
====================================

// Module: mat_vec_mult_skew
// PURPOSE
//  Parametrised ROWS x COLS matrix by COLS x 1 vector multiplier, producing a ROWS x 1 result.
//  Per-row input FIFOs feed one MAC lane per row. The vector is skewed through a delay line.
//  Row i starts i cycles after row 0.
//  Sits between the host-side write interface and the result consumer. Adds a done handshake,
//  abort and overflow flags.
// PARAMETERS
//  ROWS        8                            matrix rows = MAC lanes = result elements
//  COLS        8                            matrix columns = vector length
//  DATA_WIDTH  8                            operand width
//  FIFO_DEPTH  8                            entries per FIFO; must be >= COLS (elaboration $error otherwise)
//  ACC_WIDTH   2*DATA_WIDTH+$clog2(COLS)    accumulator/result width (default 19)
// PORTS
//  clk        in   1                     clock, all logic posedge
//  rst        in   1                     synchronous, active-high reset
//  clr        in   1                     sync clear/abort (see BEHAVIOUR)
//  a_wren     in   1                     push a_wdata[r] into every row FIFO r
//  a_wdata    in   DATA_WIDTH x ROWS     one matrix column, element r -> row r
//  b_wren     in   1                     push b_wdata into vector FIFO
//  b_wdata    in   DATA_WIDTH            one vector element
//  a_full     out  1                     OR of all row FIFO full flags
//  b_full     out  1                     vector FIFO full
//  busy       out  1                     state == RUN
//  out_valid  out  1                     1-cycle pulse, results final
//  overflow   out  1                     sticky: write attempted while full
//  out        out  ACC_WIDTH x ROWS      per-row results, held until next RUN or clr
// BEHAVIOUR
//  Reset: all FIFOs empty, accumulators 0, state IDLE.
//   All outputs 0, except a_full/b_full, which reflect the empty FIFOs (0).
//  FIFOs: first-word-fall-through. Head is valid combinationally when not empty; rden pops.
//   Push and pop in the same cycle are legal; count is unchanged.
//   Push when full: data dropped, overflow set until rst/clr.
//   Pushes are legal in every state, so the next job preloads during RUN.
//  FSM: IDLE -> RUN when every row FIFO and the b FIFO hold >= COLS entries.
//   RUN -> DONE after the cycle where t == COLS+ROWS-2. t is the RUN cycle counter, 0-based.
//   DONE -> IDLE unconditionally; out_valid = 1 in DONE only.
//  Skew: bd[0] = b FIFO head; bd[i] <= bd[i-1] each RUN cycle, zeroed in IDLE.
//   The b FIFO pops when t < COLS.
//  Lane i active when i <= t < i+COLS: pops row FIFO i.
//   At t == i: acc[i] <= a_head[i]*bd[i] (load, no stale add).
//   For later active cycles: acc[i] <= acc[i] + a_head[i]*bd[i].
//   Result: acc[i] = sum_k A[i][k]*b[k]. No truncation at defaults; the product is zero-extended to ACC_WIDTH.
//  Latency: 1 IDLE cycle detecting start, then ROWS+COLS-1 RUN cycles, then out_valid.
//   Defaults: out_valid 16 cycles after the start condition is first true.
//  clr (priority below rst, above all else):
//   Zeroes accumulators, overflow, out_valid and the skew line. State -> IDLE.
//   If asserted in RUN/DONE: all FIFOs flushed (aborted job discarded); out_valid not issued.
//   If asserted in IDLE: FIFO contents kept.
//  rst mid-RUN: identical to power-on reset.
// CONFIGURATION
//  MVM_SIGNED_EN defined:
//   Operands are two's complement; products are sign-extended to ACC_WIDTH.
//   a_head, bd and acc are declared signed.
//  Undefined: all operands and results are unsigned.
// STRUCTURE
//  Package mvm_pkg:
//   typedef enum logic [1:0] {IDLE, RUN, DONE} mvm_state_t
//   function clog2-based ACC_WIDTH helper
//  Sub-module mvm_fifo (parametrised DATA_WIDTH, FIFO_DEPTH):
//   FWFT, count output, full/empty/overflow. Instantiated ROWS+1 times.
//  MAC lanes, skew line and FSM are inline generate loops in this module.
// TESTING
//  1. Identity A (A[i][i]=1), b = {1..8} pushed:
//     out = {1..8}; out_valid exactly 16 cycles after the 8th push; busy high 15 cycles.
//  2. All A=8'hFF, b=8'hFF: every out = 520200 (no wrap in 19 bits).
//     Under MVM_SIGNED_EN, A=b=-128: every out = 131072.
//  3. Back-to-back: push job 2 during job 1 RUN.
//     Job 1 out_valid, then DONE->IDLE->RUN with no extra idle; job 2 results correct.
//  4. clr at t=5 of RUN:
//     next cycle state IDLE, out all 0, FIFOs empty, no out_valid pulse.
//     A subsequent fresh job computes correctly.
//  5. 9th push into full b FIFO: data dropped, overflow=1 sticky until clr.
//     The job still uses the first 8 elements.
//  6. rst asserted mid-RUN for 1 cycle: all outputs return to reset values next cycle.
//     Only 7 columns pushed: stays IDLE indefinitely.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared state encoding and sizing helper for the skewed matrix-vector multiplier.
package mvm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mvm_state_t;

  function automatic int mvm_acc_width(input int data_width, input int cols);
    return 2 * data_width + $clog2(cols);
  endfunction

endpackage

// File: rtl/mvm_fifo.sv
// First-word-fall-through FIFO with occupancy count and a sticky push-while-full flag.
module mvm_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  flush,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic                  push;
  logic                  pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CW'(FIFO_DEPTH));
  assign push  = wren && !full;
  assign pop   = rden && (count != '0);
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_next(wptr);
      if (pop)  rptr <= ptr_next(rptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr)       overflow <= 1'b0;
    else if (wren && full) overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/mat_vec_mult_skew.sv
// ROWS x COLS matrix times vector: one MAC lane per row, vector skewed one cycle per lane.
// Define MVM_SIGNED_EN for two's-complement operands; otherwise everything is unsigned.
module mat_vec_mult_skew
  import mvm_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ACC_WIDTH  = mvm_acc_width(DATA_WIDTH, COLS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic                                a_wren,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0]     a_wdata,
  input  logic                                b_wren,
  input  logic [DATA_WIDTH-1:0]               b_wdata,
  output logic                                a_full,
  output logic                                b_full,
  output logic                                busy,
  output logic                                out_valid,
  output logic                                overflow,
  output logic [ROWS-1:0][ACC_WIDTH-1:0]      out
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(ROWS + COLS);
  localparam logic [TW-1:0] T_LAST = TW'(COLS + ROWS - 2);

`ifdef MVM_SIGNED_EN
  typedef logic signed [DATA_WIDTH-1:0]   opnd_t;
  typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
  typedef logic signed [ACC_WIDTH-1:0]    acc_t;
`else
  typedef logic [DATA_WIDTH-1:0]          opnd_t;
  typedef logic [2*DATA_WIDTH-1:0]        prod_t;
  typedef logic [ACC_WIDTH-1:0]           acc_t;
`endif

  if (FIFO_DEPTH < COLS) begin : g_depth_chk
    $error("mat_vec_mult_skew: FIFO_DEPTH must be >= COLS");
  end

  // Full-precision product, then sign/zero extension follows opnd_t signedness.
  function automatic acc_t mul_ext(input opnd_t x, input opnd_t y);
    prod_t p;
    p = prod_t'(x) * prod_t'(y);
    return acc_t'(p);
  endfunction

  mvm_state_t    state;
  logic [TW-1:0] t;
  logic          start;
  logic          flush;
  logic          b_pop;
  logic          b_ovf;
  logic [CW-1:0] b_cnt;
  opnd_t         b_head;
  opnd_t         bd [1:ROWS-1];
  logic [CW-1:0] a_cnt [ROWS];
  logic [ROWS-1:0] a_full_v;
  logic [ROWS-1:0] a_ovf_v;

  assign flush     = clr && (state != IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE) && !clr;
  assign a_full    = |a_full_v;
  assign overflow  = (|a_ovf_v) || b_ovf;
  assign b_pop     = (state == RUN) && (t < TW'(COLS));

  always_comb begin
    start = (b_cnt >= CW'(COLS));
    for (int k = 0; k < ROWS; k++) begin
      if (a_cnt[k] < CW'(COLS)) start = 1'b0;
    end
  end

  // Control: IDLE -> RUN -> DONE -> IDLE, t counts RUN cycles from 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          t     <= '0;
        end
        RUN: begin
          if (t == T_LAST) state <= DONE;
          t <= t + TW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mvm_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk(clk), .rst(rst), .clr(clr), .flush(flush),
    .wren(b_wren), .wdata(b_wdata), .rden(b_pop), .rdata(b_head),
    .count(b_cnt), .full(b_full), .overflow(b_ovf)
  );

  // Skew stage: tap i holds the vector element lane i consumes this cycle.
  always_ff @(posedge clk) begin
    if (rst || clr || state == IDLE) begin
      for (int k = 1; k < ROWS; k++) bd[k] <= '0;
    end else if (state == RUN) begin
      bd[1] <= b_head;
      for (int k = 2; k < ROWS; k++) bd[k] <= bd[k-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    localparam logic [TW-1:0] T_LO = TW'(i);
    localparam logic [TW-1:0] T_HI = TW'(i + COLS);
    opnd_t a_head;
    opnd_t b_tap;
    acc_t  prod;
    acc_t  acc;
    logic  lo_ok;
    logic  active;

    if (i == 0) begin : g_first
      assign lo_ok = 1'b1;
      assign b_tap = b_head;
    end else begin : g_rest
      assign lo_ok = (t >= T_LO);
      assign b_tap = bd[i];
    end

    assign active = (state == RUN) && lo_ok && (t < T_HI);
    assign prod   = mul_ext(a_head, b_tap);

    mvm_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_a_fifo (
      .clk(clk), .rst(rst), .clr(clr), .flush(flush),
      .wren(a_wren), .wdata(a_wdata[i]), .rden(active), .rdata(a_head),
      .count(a_cnt[i]), .full(a_full_v[i]), .overflow(a_ovf_v[i])
    );

    // MAC stage: first active cycle loads, so no stale sum leaks between jobs.
    always_ff @(posedge clk) begin
      if (rst || clr)  acc <= '0;
      else if (active) acc <= (t == T_LO) ? prod : acc + prod;
    end

    assign out[i] = acc;
  end

endmodule

// File: tb/tb_mat_vec_mult_skew.sv
// Directed self-checking bench for mat_vec_mult_skew at default parameters.
module tb_mat_vec_mult_skew;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 8;
  localparam int AW   = 19;

  logic                        clk = 1'b0;
  logic                        rst, clr, a_wren, b_wren;
  logic [ROWS-1:0][DW-1:0]     a_wdata;
  logic [DW-1:0]               b_wdata;
  logic                        a_full, b_full, busy, out_valid, overflow;
  logic [ROWS-1:0][AW-1:0]     out;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] ma [ROWS][COLS];
  logic [DW-1:0] vb [COLS];

  always #5 clk = ~clk;

  mat_vec_mult_skew dut (
    .clk(clk), .rst(rst), .clr(clr),
    .a_wren(a_wren), .a_wdata(a_wdata),
    .b_wren(b_wren), .b_wdata(b_wdata),
    .a_full(a_full), .b_full(b_full), .busy(busy),
    .out_valid(out_valid), .overflow(overflow), .out(out)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_row(input int r);
    longint s = 0;
    for (int k = 0; k < COLS; k++) begin
`ifdef MVM_SIGNED_EN
      s += longint'($signed(ma[r][k])) * longint'($signed(vb[k]));
`else
      s += longint'(ma[r][k]) * longint'(vb[k]);
`endif
    end
    return s & ((longint'(1) << AW) - 1);
  endfunction

  task automatic set_in(input logic aw, input logic bw, input int k, input logic c, input logic r);
    a_wren = aw;
    b_wren = bw;
    clr    = c;
    rst    = r;
    for (int i = 0; i < ROWS; i++) a_wdata[i] = '0;
    b_wdata = '0;
    if (k >= 0) begin
      for (int i = 0; i < ROWS; i++) a_wdata[i] = ma[i][k];
      b_wdata = vb[k];
    end
  endtask

  task automatic drive(input logic aw, input logic bw, input int k, input logic c, input logic r);
    @(negedge clk);
    set_in(aw, bw, k, c, r);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic push_job();
    for (int k = 0; k < COLS; k++) drive(1'b1, 1'b1, k, 1'b0, 1'b0);
  endtask

  // c = 0 is the first cycle after the last push (the start-detect cycle).
  task automatic wait_done(output int lat, output int bcnt, output logic seen);
    seen = 1'b0;
    lat  = -1;
    bcnt = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      idle();
      if (busy) bcnt++;
      if (out_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
  endtask

  task automatic wait_busy(output logic seen);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      idle();
      if (busy) seen = 1'b1;
    end
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < ROWS; r++) chk($sformatf("%s_out%0d", tag, r), longint'(out[r]), exp_row(r));
  endtask

  task automatic check_zero_outs(input string tag);
    for (int r = 0; r < ROWS; r++) chk($sformatf("%s_out%0d", tag, r), longint'(out[r]), 0);
  endtask

  int   lat, bcnt, v_at, b_at, j2, cnt;
  logic seen;

  initial begin
    set_in(1'b0, 1'b0, -1, 1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0, -1, 1'b0, 1'b1);
    idle();
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_a_full", a_full, 0);
    chk("rst_b_full", b_full, 0);
    check_zero_outs("rst");

    // 1: identity matrix, b = 1..8
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) ma[r][k] = (r == k) ? 8'd1 : 8'd0;
    for (int k = 0; k < COLS; k++) vb[k] = 8'(k + 1);
    push_job();
    wait_done(lat, bcnt, seen);
    chk("t1_done_seen", seen, 1);
    chk("t1_latency", lat, 16);
    chk("t1_busy_cycles", bcnt, 15);
    for (int r = 0; r < ROWS; r++) chk($sformatf("t1_out%0d", r), longint'(out[r]), r + 1);
    idle();
    chk("t1_valid_pulse", out_valid, 0);
    chk("t1_out_held", longint'(out[7]), 8);

    // 2: extreme operands
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) begin
`ifdef MVM_SIGNED_EN
        ma[r][k] = 8'h80;
`else
        ma[r][k] = 8'hFF;
`endif
      end
    for (int k = 0; k < COLS; k++) vb[k] = ma[0][0];
    push_job();
    wait_done(lat, bcnt, seen);
    chk("t2_done_seen", seen, 1);
    for (int r = 0; r < ROWS; r++) begin
`ifdef MVM_SIGNED_EN
      chk($sformatf("t2_out%0d", r), longint'(out[r]), 131072);
`else
      chk($sformatf("t2_out%0d", r), longint'(out[r]), 520200);
`endif
    end

    // 3: back-to-back, job 2 preloaded during job 1 RUN
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) ma[r][k] = 8'(r + k);
    for (int k = 0; k < COLS; k++) vb[k] = 8'd1;
    push_job();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) ma[r][k] = 8'(r + 1);
    for (int k = 0; k < COLS; k++) vb[k] = 8'(k + 1);
    j2 = 0; v_at = -1; b_at = -1;
    for (int c = 0; c < 80 && b_at < 0; c++) begin
      @(negedge clk);
      if (v_at >= 0 && busy) b_at = c;
      if (out_valid && v_at < 0) begin
        v_at = c;
        for (int r = 0; r < ROWS; r++) chk($sformatf("t3_job1_out%0d", r), longint'(out[r]), 8 * r + 28);
      end
      if (j2 < COLS && !a_full && !b_full) begin
        set_in(1'b1, 1'b1, j2, 1'b0, 1'b0);
        j2++;
      end else begin
        set_in(1'b0, 1'b0, -1, 1'b0, 1'b0);
      end
    end
    chk("t3_job1_valid_seen", (v_at >= 0), 1);
    chk("t3_job2_pushed", j2, COLS);
    chk("t3_done_to_run_gap", b_at - v_at, 2);
    wait_done(lat, bcnt, seen);
    chk("t3_job2_done_seen", seen, 1);
    for (int r = 0; r < ROWS; r++) chk($sformatf("t3_job2_out%0d", r), longint'(out[r]), 36 * (r + 1));

    // 4: clr at t = 5 aborts and flushes
    push_job();
    wait_busy(seen);
    chk("t4_run_seen", seen, 1);
    repeat (4) idle();
    chk("t4_busy_before_clr", busy, 1);
    chk("t4_partial_nonzero", (out[0] != '0), 1);
    drive(1'b0, 1'b0, -1, 1'b1, 1'b0);
    idle();
    chk("t4_busy_after_clr", busy, 0);
    chk("t4_a_full_after_clr", a_full, 0);
    check_zero_outs("t4_clr");
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      idle();
      if (out_valid || busy) cnt++;
    end
    chk("t4_no_valid_or_run", cnt, 0);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) ma[r][k] = 8'(r);
    for (int k = 0; k < COLS; k++) vb[k] = 8'(k);
    push_job();
    wait_done(lat, bcnt, seen);
    chk("t4_fresh_done_seen", seen, 1);
    chk("t4_fresh_latency", lat, 16);
    for (int r = 0; r < ROWS; r++) chk($sformatf("t4_fresh_out%0d", r), longint'(out[r]), 28 * r);
    chk("t4_fresh_no_overflow", overflow, 0);

    // 5: ninth push into a full b FIFO
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) ma[r][k] = 8'd1;
    for (int k = 0; k < COLS; k++) vb[k] = 8'(k + 1);
    push_job();
    @(negedge clk);
    chk("t5_b_full", b_full, 1);
    set_in(1'b0, 1'b0, -1, 1'b0, 1'b0);
    b_wren  = 1'b1;
    b_wdata = 8'd100;
    idle();
    chk("t5_overflow_set", overflow, 1);
    wait_done(lat, bcnt, seen);
    chk("t5_done_seen", seen, 1);
    for (int r = 0; r < ROWS; r++) chk($sformatf("t5_out%0d", r), longint'(out[r]), 36);
    idle();
    chk("t5_overflow_sticky", overflow, 1);
    drive(1'b0, 1'b0, -1, 1'b1, 1'b0);
    idle();
    chk("t5_overflow_cleared", overflow, 0);

    // 6: rst mid-RUN, then an incomplete job, then clr in IDLE keeps contents
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) ma[r][k] = 8'(r + k);
    for (int k = 0; k < COLS; k++) vb[k] = 8'd1;
    push_job();
    wait_busy(seen);
    chk("t6_run_seen", seen, 1);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle();
    chk("t6_a_full_mid_run", a_full, 1);
    chk("t6_a_overflow_mid_run", overflow, 1);
    drive(1'b0, 1'b0, -1, 1'b0, 1'b1);
    idle();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_overflow", overflow, 0);
    chk("t6_rst_a_full", a_full, 0);
    chk("t6_rst_b_full", b_full, 0);
    check_zero_outs("t6_rst");
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) ma[r][k] = 8'(r ^ k);
    for (int k = 0; k < COLS; k++) vb[k] = 8'(k + 2);
    for (int k = 0; k < COLS - 1; k++) drive(1'b1, 1'b1, k, 1'b0, 1'b0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      idle();
      if (busy || out_valid) cnt++;
    end
    chk("t6_seven_cols_idle", cnt, 0);
    drive(1'b0, 1'b0, -1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, COLS - 1, 1'b0, 1'b0);
    wait_done(lat, bcnt, seen);
    chk("t6_done_seen", seen, 1);
    check_rows("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
